// File: rtl/rdl_wide_reg_ctrl_if.sv
// rdl_wide_reg_ctrl_if: request/response bus for the wide register controller
interface rdl_wide_reg_ctrl_if #(
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [2:0]    req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/rdl_wide_reg_ctrl.sv
// rdl_wide_reg_ctrl: wide register with atomic multi-word software commit and hw update
module rdl_wide_reg_ctrl #(
    parameter int DW = 32,
    parameter int NW = 2,
    parameter logic [NW*DW-1:0] ResetValue = '0
) (
    input  logic               clk,
    input  logic               rst,
    rdl_wide_reg_ctrl_if.slave bus,
    input  logic               hw_de,
    input  logic [NW*DW-1:0]   hw_d,
    output logic [NW*DW-1:0]   q,
    output logic               commit
);
    typedef enum logic {IDLE, RESP} state_t;
    state_t state, state_nx;
    logic [NW-1:0][DW-1:0] q_r;
    logic [NW-2:0][DW-1:0] shadow;
    logic [NW-2:0]         mask;
    logic [NW-1:1][DW-1:0] snap;
    logic                  accept, addr_ok, last, full, wr, sw_commit, err;
    logic [DW-1:0]         rd;
    assign bus.req_ready = (state == IDLE);
    assign accept    = bus.req_ready && bus.req_valid;
    assign addr_ok   = {1'b0, bus.req_addr} < 4'(NW);
    assign last      = bus.req_addr == 3'(NW-1);
    assign full      = &mask;
    assign wr        = accept && bus.req_write && addr_ok;
    assign sw_commit = wr && last && full;
    assign err       = !addr_ok || (bus.req_write && last && !full);
    assign q         = q_r;
    // word 0 reads live q; upper words read the snapshot taken at the last word-0 read
    always_comb begin
        state_nx = (state == RESP) ? IDLE : (bus.req_valid ? RESP : IDLE);
        rd = (bus.req_addr == 3'd0) ? q_r[0] : '0;
        for (int i = 1; i < NW; i++)
            if (bus.req_addr == 3'(i)) rd = snap[i];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            q_r           <= ResetValue;
            shadow        <= ResetValue[(NW-1)*DW-1:0];
            mask          <= '0;
            snap          <= ResetValue[NW*DW-1:DW];
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            commit        <= 1'b0;
        end else begin
            state         <= state_nx;
            bus.rsp_valid <= accept;
            bus.rsp_err   <= accept && err;
            bus.rsp_rdata <= (accept && !bus.req_write && addr_ok) ? rd : '0;
            commit        <= sw_commit;
            q_r           <= sw_commit ? {bus.req_wdata, shadow} : (hw_de ? hw_d : q_r);
            if (wr && last) mask <= '0;
            for (int i = 0; i < NW-1; i++)
                if (wr && bus.req_addr == 3'(i)) begin
                    shadow[i] <= bus.req_wdata;
                    mask[i]   <= 1'b1;
                end
            if (accept && !bus.req_write && bus.req_addr == 3'd0) snap <= q_r[NW-1:1];
        end
    end
endmodule

// File: tb/tb_rdl_wide_reg_ctrl.sv
// tb_rdl_wide_reg_ctrl: directed literal checks plus randomized traffic against a transaction-level model
module tb_rdl_wide_reg_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hw_de = 1'b0;
    logic [63:0] hw_d = '0;
    logic [63:0] q;
    logic        commit;
    int          checks = 0;
    int          errors = 0;
    rdl_wide_reg_ctrl_if #(.DW(32)) bus();
    rdl_wide_reg_ctrl #(.DW(32), .NW(2), .ResetValue('0)) dut (
        .clk(clk), .rst(rst), .bus(bus), .hw_de(hw_de), .hw_d(hw_d), .q(q), .commit(commit)
    );
    always #5 clk = ~clk;
    bit          busy = 0;
    logic [63:0] mq = '0;
    logic [31:0] m_shadow = '0;
    logic [31:0] m_snap = '0;
    bit          m_mask = 0;
    bit          e_valid = 0, e_err = 0, e_commit = 0;
    logic [31:0] e_rdata = '0;
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask
    // transaction-level reference: one accepted request per idle cycle, software commit beats hw
    always @(posedge clk) begin
        bit          acc;
        logic [63:0] nq;
        if (rst) begin
            busy = 0; mq = '0; m_shadow = '0; m_snap = '0; m_mask = 0;
            e_valid = 0; e_err = 0; e_commit = 0; e_rdata = '0;
        end else begin
            acc = !busy && bus.req_valid;
            e_valid = acc; e_err = 0; e_commit = 0; e_rdata = '0;
            nq = hw_de ? hw_d : mq;
            if (acc) begin
                if (bus.req_addr >= 3'd2) e_err = 1;
                else if (bus.req_write && bus.req_addr == 3'd0) begin
                    m_shadow = bus.req_wdata; m_mask = 1;
                end else if (bus.req_write) begin
                    if (m_mask) begin nq = {bus.req_wdata, m_shadow}; e_commit = 1; end
                    else e_err = 1;
                    m_mask = 0;
                end else if (bus.req_addr == 3'd0) begin
                    e_rdata = mq[31:0]; m_snap = mq[63:32];
                end else e_rdata = m_snap;
            end
            mq = nq;
            busy = acc;
        end
    end
    always @(negedge clk) begin
        chk("req_ready", 64'(bus.req_ready), 64'(!busy));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_valid));
        chk("rsp_err",   64'(bus.rsp_err),   64'(e_err));
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e_rdata));
        chk("commit",    64'(commit),        64'(e_commit));
        chk("q",         q,                  mq);
    end
    task automatic idle_bus();
        bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_wdata = '0;
    endtask
    task automatic req(input bit w, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.req_valid = 1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
        @(negedge clk);
        idle_bus();
    endtask
    task automatic reset_dut();
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
    endtask
    task automatic hw_pulse(input logic [63:0] v);
        @(negedge clk); hw_de = 1; hw_d = v;
        @(negedge clk); hw_de = 0;
    endtask
    initial begin
        idle_bus();
        repeat (2) @(negedge clk);
        chk("lit_reset_q", q, 64'h0);
        chk("lit_reset_valid", 64'(bus.rsp_valid), 64'h0);
        rst = 0;
        req(1, 3'd0, 32'h1111_1111);
        chk("lit_w0_err", 64'(bus.rsp_err), 64'h0);
        req(1, 3'd1, 32'h2222_2222);
        chk("lit_w1_err", 64'(bus.rsp_err), 64'h0);
        chk("lit_commit_pulse", 64'(commit), 64'h1);
        chk("lit_q_commit", q, 64'h2222_2222_1111_1111);
        @(negedge clk);
        chk("lit_commit_once", 64'(commit), 64'h0);
        reset_dut();
        req(1, 3'd1, 32'hAAAA_AAAA);
        chk("lit_nomask_err", 64'(bus.rsp_err), 64'h1);
        chk("lit_nomask_q", q, 64'h0);
        chk("lit_nomask_commit", 64'(commit), 64'h0);
        hw_pulse(64'h5_0000_0004);
        req(0, 3'd0, '0);
        chk("lit_rd_w0", 64'(bus.rsp_rdata), 64'h4);
        hw_pulse(64'h9_0000_0009);
        req(0, 3'd1, '0);
        chk("lit_rd_snap", 64'(bus.rsp_rdata), 64'h5);
        chk("lit_q_hw", q, 64'h9_0000_0009);
        req(1, 3'd0, 32'h33);
        @(negedge clk);
        bus.req_valid = 1; bus.req_write = 1; bus.req_addr = 3'd1; bus.req_wdata = 32'h44;
        hw_de = 1; hw_d = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        idle_bus(); hw_de = 0;
        chk("lit_sw_wins_q", q, 64'h44_0000_0033);
        chk("lit_sw_wins_commit", 64'(commit), 64'h1);
        req(0, 3'd2, '0);
        chk("lit_badaddr_err", 64'(bus.rsp_err), 64'h1);
        chk("lit_badaddr_rdata", 64'(bus.rsp_rdata), 64'h0);
        @(negedge clk);
        bus.req_valid = 1; bus.req_addr = 3'd0;
        for (int i = 0; i < 4; i++) begin
            chk("lit_ready_alt", 64'(bus.req_ready), 64'((i % 2) == 0));
            @(negedge clk);
        end
        idle_bus();
        req(1, 3'd0, 32'h77);
        reset_dut();
        req(1, 3'd1, 32'h88);
        chk("lit_rst_mask_err", 64'(bus.rsp_err), 64'h1);
        chk("lit_rst_mask_q", q, 64'h0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst         = ($urandom_range(0, 99) == 0);
            bus.req_valid = ($urandom_range(0, 9) < 6);
            bus.req_write = ($urandom_range(0, 9) < 6);
            bus.req_addr  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
            bus.req_wdata = $urandom;
            hw_de       = ($urandom_range(0, 9) < 2);
            hw_d        = {$urandom, $urandom};
        end
        @(negedge clk);
        rst = 0; idle_bus(); hw_de = 0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rdl_wide_reg_ctrl.md
RDL_WIDE_REG_CTRL -- requirements
Module: rdl_wide_reg_ctrl

Interface
REQ-001 Parameter DW, default 32: bus word width in bits.
REQ-002 Parameter NW, default 2, legal range 2..8: number of bus words in the wide register.
REQ-003 Parameter ResetValue [NW*DW-1:0], default '0: reset value of the wide register.
REQ-004 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 req_valid  in  1  bus request present.
REQ-008 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-009 req_write  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  3  word index; index 0 is least significant.
REQ-011 req_wdata  in  DW  write data.
REQ-012 rsp_valid  out  1  one-cycle response strobe.
REQ-013 rsp_rdata  out  DW  read data; 0 for writes and errors.
REQ-014 rsp_err  out  1  error flag, qualified by rsp_valid.
REQ-015 hw_de  in  1  hardware update enable.
REQ-016 hw_d  in  NW*DW  hardware update value.
REQ-017 q  out  NW*DW  committed wide register value.
REQ-018 commit  out  1  one-cycle pulse; q was loaded from a software write on the preceding edge.

Function
REQ-019 FSM states SHALL be IDLE and RESP; req_ready = (state == IDLE).
REQ-020 Accepting a request in IDLE SHALL move to RESP; RESP SHALL return to IDLE unconditionally after one cycle.
REQ-021 rsp_valid SHALL be high exactly in the RESP cycle: latency 1 cycle, throughput 1 request per 2 cycles.
REQ-022 req_addr >= NW SHALL give rsp_err=1, rsp_rdata=0, and no change to q, shadow, mask or snapshot.
REQ-023 Write to word k < NW-1 SHALL store req_wdata into shadow word k and set mask bit k; no change to q.
REQ-024 Write to word NW-1 with mask bits 0..NW-2 all set SHALL load q <= {req_wdata, shadow[NW-2:0]}, clear the mask, and give rsp_err=0.
REQ-025 Write to word NW-1 with any mask bit clear SHALL leave q unchanged, clear the mask, and give rsp_err=1.
REQ-026 A repeated write to word k before commit SHALL overwrite shadow word k; the last value wins.
REQ-027 commit SHALL be high in the cycle after the edge at which a REQ-024 load occurs, and low otherwise.
REQ-028 Read of word 0 SHALL return q word 0 and, on the same edge, capture q words 1..NW-1 into the snapshot.
REQ-029 Read of word k > 0 SHALL return snapshot word k, not live q.
REQ-030 rsp_rdata SHALL be registered at acceptance and held 0 whenever rsp_valid = 0.
REQ-031 hw_de=1 SHALL load q <= hw_d on that edge, unless a REQ-024 commit occurs on the same edge, in which case software wins and hw_d is dropped.
REQ-032 hw_de SHALL NOT alter shadow, mask, snapshot or the FSM.
REQ-033 A read of word 0 coincident with hw_de SHALL return and snapshot pre-update q.
REQ-034 req_valid in RESP SHALL be ignored; the requester holds it until req_ready.

Reset
REQ-035 On rst=1 at an edge: state=IDLE, q=ResetValue, shadow=ResetValue[(NW-1)*DW-1:0], mask=0, snapshot=ResetValue, rsp_valid=0, rsp_rdata=0, rsp_err=0, commit=0.
REQ-036 rst SHALL override all concurrent activity; a request in flight is discarded with no response, and partial writes are lost.

Verification (NW=2, DW=32, ResetValue=0)
REQ-037 Write w0=0x1111_1111, then w1=0x2222_2222 -> q=0x2222_2222_1111_1111; commit pulses once; both rsp_err=0.
REQ-038 After reset, write w1=0xAAAA_AAAA with no prior w0 -> rsp_err=1, q stays 0, commit stays 0.
REQ-039 q=0x5_0000_0004; read w0 -> 0x4; then hw_de with hw_d=0x9_0000_0009; read w1 -> 0x5 from the snapshot.
REQ-040 Write w1 accepted on the same edge as hw_de=1 -> q takes the software value; commit=1.
REQ-041 Read with req_addr=2 -> rsp_err=1, rsp_rdata=0; back-to-back req_valid -> req_ready alternates 1,0.
REQ-042 Write w0, assert rst, then write w1 -> rsp_err=1 because the mask was cleared by reset.
